// File: rtl/r5p_degu_tcb_trc.sv
// Retirement tracer for R5P-degu: snoops TCB transfers with the core phase,
// assembles one record per retired instruction and queues it for a trace sink.
module r5p_degu_tcb_trc #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       pha,
    input  logic             tcb_vld,
    input  logic             tcb_rdy,
    input  logic             tcb_wen,
    input  logic [31:0]      tcb_adr,
    input  logic [1:0]       tcb_siz,
    input  logic             tcb_uns,
    input  logic [31:0]      tcb_wdt,
    input  logic [31:0]      tcb_rdt,
    input  logic             tcb_err,
    output logic             trc_vld,
    input  logic             trc_rdy,
    output logic [31:0]      trc_pc,
    output logic [31:0]      trc_ins,
    output logic             trc_rdv,
    output logic [4:0]       trc_rdi,
    output logic [31:0]      trc_rdd,
    output logic             trc_ldv,
    output logic             trc_stv,
    output logic [31:0]      trc_mad,
    output logic [31:0]      trc_mdt,
    output logic             trc_err,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [2:0] PHA_IF  = 3'b000;
    localparam logic [2:0] PHA_MLD = 3'b001;
    localparam logic [2:0] PHA_MST = 3'b010;
    localparam logic [2:0] PHA_WB  = 3'b100;

    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        rdv;
        logic [4:0]  rdi;
        logic [31:0] rdd;
        logic        ldv;
        logic        stv;
        logic [31:0] mad;
        logic [31:0] mdt;
        logic        err;
    } rec_t;

    logic        trn;
    logic        d_trn;
    logic [2:0]  d_pha;
    logic        d_wen;
    logic [31:0] d_adr;
    logic [1:0]  d_siz;
    logic        d_uns;
    logic [31:0] d_wdt;

    rec_t        rec;
    rec_t        rec_nxt;
    logic        open;
    logic        open_nxt;
    logic        live;
    logic        live_nxt;
    logic        emit;

    rec_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    rec_t        head;

    assign trn = tcb_vld & tcb_rdy;

    // Transfer-valid flag of the delayed request stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_trn <= 1'b0;
        end else begin
            d_trn <= trn;
        end
    end

    // Request fields held until the response arrives one cycle later.
    always_ff @(posedge clk) begin
        if (trn) begin
            d_pha <= pha;
            d_wen <= tcb_wen;
            d_adr <= tcb_adr;
            d_siz <= tcb_siz;
            d_uns <= tcb_uns;
            d_wdt <= tcb_wdt;
        end
    end

    // Record assembly: 'open' marks the reset JAL seen, 'live' a real record in progress.
    always_comb begin
        rec_nxt  = rec;
        open_nxt = open;
        live_nxt = live;
        emit     = 1'b0;
        if (d_trn) begin
            case (d_pha)
                PHA_IF: begin
                    emit        = live;
                    live_nxt    = open;
                    open_nxt    = 1'b1;
                    rec_nxt.pc  = d_adr;
                    rec_nxt.ins = tcb_rdt;
                    rec_nxt.rdv = 1'b0;
                    rec_nxt.ldv = 1'b0;
                    rec_nxt.stv = 1'b0;
                    rec_nxt.err = tcb_err;
                end
                PHA_WB: begin
                    // x0 writes are issued with a different size and carry no GPR update
                    if ({d_uns, d_siz} == 3'b010) begin
                        rec_nxt.rdv = 1'b1;
                        rec_nxt.rdi = d_adr[6:2];
                        rec_nxt.rdd = d_wen ? d_wdt : tcb_rdt;
                    end else begin
                        rec_nxt.rdv = rec.rdv;
                    end
                    rec_nxt.err = rec.err | tcb_err;
                end
                PHA_MLD: begin
                    rec_nxt.ldv = 1'b1;
                    rec_nxt.mad = d_adr;
                    rec_nxt.mdt = tcb_rdt;
                    rec_nxt.err = rec.err | tcb_err;
                end
                PHA_MST: begin
                    rec_nxt.stv = 1'b1;
                    rec_nxt.mad = d_adr;
                    rec_nxt.mdt = d_wdt;
                    rec_nxt.err = rec.err | tcb_err;
                end
                default: begin
                    rec_nxt.err = rec.err | tcb_err;
                end
            endcase
        end else begin
            emit = 1'b0;
        end
    end

    // Assembly record and fetch-sequence flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec  <= '0;
            open <= 1'b0;
            live <= 1'b0;
        end else begin
            rec  <= rec_nxt;
            open <= open_nxt;
            live <= live_nxt;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);
    assign pop   = trc_vld & trc_rdy;
    assign push  = emit & (~full | pop);

    // FIFO storage; head is only exposed while non-empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= rec;
        end
    end

    // FIFO pointers and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (emit && full && !pop && !(&ovf_cnt)) begin
                ovf_cnt <= ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Head entry, forced to zero while the FIFO is empty.
    always_comb begin
        if (empty) begin
            head = '0;
        end else begin
            head = mem[rd_ptr[AW-1:0]];
        end
    end

    assign trc_vld = ~empty;
    assign trc_pc  = head.pc;
    assign trc_ins = head.ins;
    assign trc_rdv = head.rdv;
    assign trc_rdi = head.rdi;
    assign trc_rdd = head.rdd;
    assign trc_ldv = head.ldv;
    assign trc_stv = head.stv;
    assign trc_mad = head.mad;
    assign trc_mdt = head.mdt;
    assign trc_err = head.err;

endmodule

// File: tb/tb_r5p_degu_tcb_trc.sv
// Bench for r5p_degu_tcb_trc: directed scenarios plus random traffic, all
// compared every cycle against a transaction-level record/queue model.
module tb_r5p_degu_tcb_trc;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;
    localparam int OVF_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        rdv;
        logic [4:0]  rdi;
        logic [31:0] rdd;
        logic        ldv;
        logic        stv;
        logic [31:0] mad;
        logic [31:0] mdt;
        logic        err;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       pha = 3'b000;
    logic             tcb_vld = 1'b0;
    logic             tcb_rdy = 1'b0;
    logic             tcb_wen = 1'b0;
    logic [31:0]      tcb_adr = 32'h0;
    logic [1:0]       tcb_siz = 2'b00;
    logic             tcb_uns = 1'b0;
    logic [31:0]      tcb_wdt = 32'h0;
    logic [31:0]      tcb_rdt = 32'h0;
    logic             tcb_err = 1'b0;
    logic             trc_vld;
    logic             trc_rdy = 1'b0;
    logic [31:0]      trc_pc;
    logic [31:0]      trc_ins;
    logic             trc_rdv;
    logic [4:0]       trc_rdi;
    logic [31:0]      trc_rdd;
    logic             trc_ldv;
    logic             trc_stv;
    logic [31:0]      trc_mad;
    logic [31:0]      trc_mdt;
    logic             trc_err;
    logic [CNT_W-1:0] ovf_cnt;

    r5p_degu_tcb_trc #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pha(pha),
        .tcb_vld(tcb_vld), .tcb_rdy(tcb_rdy), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr),
        .tcb_siz(tcb_siz), .tcb_uns(tcb_uns), .tcb_wdt(tcb_wdt), .tcb_rdt(tcb_rdt),
        .tcb_err(tcb_err),
        .trc_vld(trc_vld), .trc_rdy(trc_rdy), .trc_pc(trc_pc), .trc_ins(trc_ins),
        .trc_rdv(trc_rdv), .trc_rdi(trc_rdi), .trc_rdd(trc_rdd), .trc_ldv(trc_ldv),
        .trc_stv(trc_stv), .trc_mad(trc_mad), .trc_mdt(trc_mdt), .trc_err(trc_err),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    rec_t        mq [$];
    rec_t        m_rec  = '0;
    int          m_ovf  = 0;
    int          m_nif  = 0;
    logic        m_ptrn = 1'b0;
    logic [2:0]  m_ppha;
    logic        m_pwen;
    logic [31:0] m_padr;
    logic [2:0]  m_pf3;
    logic [31:0] m_pwdt;

    logic [31:0] pend_rdt = 32'h0;
    logic        pend_err = 1'b0;
    logic        sink     = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock edge of the reference model, using the inputs about to be sampled.
    task automatic model_step();
        int          pre;
        logic        pop;
        logic        emit;
        rec_t        out;
        logic [31:0] data;
        if (rst) begin
            mq.delete();
            m_rec  = '0;
            m_ovf  = 0;
            m_nif  = 0;
            m_ptrn = 1'b0;
            return;
        end
        pre  = mq.size();
        pop  = (pre != 0) && trc_rdy;
        emit = 1'b0;
        out  = '0;
        if (m_ptrn) begin
            data = m_pwen ? m_pwdt : tcb_rdt;
            if (m_ppha == 3'b000) begin
                // the reset JAL and the record it opens are never traced
                if (m_nif == 2) begin
                    emit = 1'b1;
                    out  = m_rec;
                end else begin
                    m_nif++;
                end
                m_rec.pc  = m_padr;
                m_rec.ins = tcb_rdt;
                m_rec.rdv = 1'b0;
                m_rec.ldv = 1'b0;
                m_rec.stv = 1'b0;
                m_rec.err = tcb_err;
            end else begin
                m_rec.err = m_rec.err | tcb_err;
                if (m_ppha == 3'b100 && m_pf3 == 3'b010) begin
                    m_rec.rdv = 1'b1;
                    m_rec.rdi = m_padr[6:2];
                    m_rec.rdd = data;
                end
                if (m_ppha == 3'b001) begin
                    m_rec.ldv = 1'b1;
                    m_rec.mad = m_padr;
                    m_rec.mdt = tcb_rdt;
                end
                if (m_ppha == 3'b010) begin
                    m_rec.stv = 1'b1;
                    m_rec.mad = m_padr;
                    m_rec.mdt = m_pwdt;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (emit) begin
            if (pre < DEPTH || pop) mq.push_back(out);
            else if (m_ovf < OVF_MAX) m_ovf++;
        end
        m_ptrn = tcb_vld & tcb_rdy;
        if (m_ptrn) begin
            m_ppha = pha;
            m_pwen = tcb_wen;
            m_padr = tcb_adr;
            m_pf3  = {tcb_uns, tcb_siz};
            m_pwdt = tcb_wdt;
        end
    endtask

    task automatic check_model();
        rec_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        check_eq("vld", trc_vld, mq.size() != 0);
        check_eq("pc",  trc_pc,  h.pc);
        check_eq("ins", trc_ins, h.ins);
        check_eq("rdv", trc_rdv, h.rdv);
        check_eq("rdi", trc_rdi, h.rdi);
        check_eq("rdd", trc_rdd, h.rdd);
        check_eq("ldv", trc_ldv, h.ldv);
        check_eq("stv", trc_stv, h.stv);
        check_eq("mad", trc_mad, h.mad);
        check_eq("mdt", trc_mdt, h.mdt);
        check_eq("err", trc_err, h.err);
        check_eq("ovf", ovf_cnt, m_ovf);
    endtask

    // Drive one cycle (called at a negedge), step the model, then check after the edge.
    task automatic cyc(input logic v, input logic r, input logic [2:0] p, input logic w,
                       input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                       input logic [31:0] rd_n, input logic er_n);
        tcb_rdt = pend_rdt;
        tcb_err = pend_err;
        tcb_vld = v;
        tcb_rdy = r;
        pha     = p;
        tcb_wen = w;
        tcb_adr = a;
        {tcb_uns, tcb_siz} = f3;
        tcb_wdt = wd;
        trc_rdy = sink;
        pend_rdt = rd_n;
        pend_err = er_n;
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic xf(input logic [2:0] p, input logic w, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, input logic [31:0] rd_n, input logic er_n);
        cyc(1'b1, 1'b1, p, w, a, f3, wd, rd_n, er_n);
    endtask

    task automatic idle();
        cyc(1'b0, 1'($urandom % 2), 3'($urandom), 1'($urandom), $urandom, 3'($urandom),
            $urandom, $urandom, 1'($urandom % 2));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    initial begin
        int sink_p;
        do_reset();
        check_eq("rst_vld", trc_vld, 1'b0);
        check_eq("rst_ovf", ovf_cnt, 3'd0);

        // basic record: reset JAL, addi x1,x0,5 with its write-back, next fetch
        sink = 1'b0;
        xf(3'b000, 1'b0, 32'h0,  3'b010, 32'h0, 32'h0000006F, 1'b0);
        xf(3'b000, 1'b0, 32'h80, 3'b010, 32'h0, 32'h00500093, 1'b0);
        xf(3'b100, 1'b1, 32'h4,  3'b010, 32'h5, 32'h0,        1'b0);
        xf(3'b000, 1'b0, 32'h84, 3'b010, 32'h0, 32'h00002083, 1'b0);
        idle();
        check_eq("s1_vld", trc_vld, 1'b1);
        check_eq("s1_pc",  trc_pc,  32'h80);
        check_eq("s1_ins", trc_ins, 32'h00500093);
        check_eq("s1_rdv", trc_rdv, 1'b1);
        check_eq("s1_rdi", trc_rdi, 5'd1);
        check_eq("s1_rdd", trc_rdd, 32'h5);
        check_eq("s1_ldv", {trc_ldv, trc_stv}, 2'b00);
        sink = 1'b1;
        idle();
        check_eq("s1_only", trc_vld, 1'b0);
        sink = 1'b0;

        // load, store, x0 write-back and a response error
        xf(3'b001, 1'b0, 32'h1000, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
        xf(3'b000, 1'b0, 32'h88,   3'b010, 32'h0, 32'h00402023, 1'b0);
        xf(3'b010, 1'b1, 32'h2004, 3'b010, 32'h12345678, 32'h0, 1'b0);
        xf(3'b000, 1'b0, 32'h8C,   3'b010, 32'h0, 32'h00000013, 1'b0);
        xf(3'b101, 1'b0, 32'h0,    3'b010, 32'h0, 32'h0, 1'b1);
        xf(3'b100, 1'b1, 32'h0,    3'b000, 32'h7, 32'h0, 1'b0);
        xf(3'b000, 1'b0, 32'h90,   3'b010, 32'h0, 32'h0, 1'b0);
        idle();
        check_eq("ld_ldv", trc_ldv, 1'b1);
        check_eq("ld_mad", trc_mad, 32'h1000);
        check_eq("ld_mdt", trc_mdt, 32'hDEADBEEF);
        sink = 1'b1;
        idle();
        sink = 1'b0;
        check_eq("st_stv", trc_stv, 1'b1);
        check_eq("st_mad", trc_mad, 32'h2004);
        check_eq("st_mdt", trc_mdt, 32'h12345678);
        sink = 1'b1;
        idle();
        sink = 1'b0;
        check_eq("x0_rdv", trc_rdv, 1'b0);
        check_eq("x0_err", trc_err, 1'b1);

        // overflow: DEPTH+3 records into a stalled sink
        do_reset();
        for (int i = 0; i < DEPTH + 5; i++) begin
            xf(3'b000, 1'b0, 32'(i * 4), 3'b010, 32'h0, $urandom, 1'b0);
        end
        idle();
        check_eq("ovf_cnt3", ovf_cnt, 3'd3);
        check_eq("ovf_vld",  trc_vld, 1'b1);
        xf(3'b000, 1'b0, 32'h100, 3'b010, 32'h0, $urandom, 1'b0);
        sink = 1'b1;
        idle();
        check_eq("pushpop_ovf", ovf_cnt, 3'd3);
        check_eq("pushpop_occ", mq.size(), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) idle();
        check_eq("drain_vld", trc_vld, 1'b0);

        // reset in the middle of a record
        sink = 1'b0;
        for (int i = 0; i < 3; i++) xf(3'b000, 1'b0, 32'(32'h200 + i * 4), 3'b010, 32'h0, $urandom, 1'b0);
        idle();
        xf(3'b100, 1'b1, 32'h8, 3'b010, 32'h9, 32'h0, 1'b0);
        do_reset();
        check_eq("mid_rst_vld", trc_vld, 1'b0);
        for (int i = 0; i < 3; i++) begin
            xf(3'b000, 1'b0, 32'(32'h300 + i * 4), 3'b010, 32'h0, $urandom, 1'b0);
            idle();
            check_eq("mid_rst_if", trc_vld, i == 2);
        end

        // random traffic
        sink_p = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) sink_p = $urandom_range(0, 4);
            sink = ($urandom_range(0, 3) < sink_p);
            if ($urandom % 700 == 0) begin
                do_reset();
            end else if ($urandom % 4 == 0) begin
                idle();
            end else begin
                cyc(1'($urandom % 4 != 0), 1'($urandom % 4 != 0),
                    ($urandom % 3 == 0) ? 3'b000 : 3'($urandom),
                    1'($urandom), $urandom,
                    ($urandom % 2 == 0) ? 3'b010 : 3'($urandom),
                    $urandom, $urandom, 1'($urandom % 16 == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/r5p_degu_tcb_trc.md
Name: r5p_degu_tcb_trc

Overview:
- Synthesizable retirement tracer for R5P-degu, downstream of the core's TCB system bus, in parallel with the execution logger.
- Snoops every TCB transfer together with the core's phase code.
- Assembles one record per retired instruction: PC, instruction, GPR write-back, load/store access.
- Pushes records into an internal FIFO drained by a valid/ready stream to a trace sink (debug RAM, UART encoder).

Parameters:
- DEPTH, 8, FIFO entries; power of two, range 2..64.
- CNT_W, 16, width of the saturating overflow counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- pha  input  3  core phase: IF=000, RS1=101, RS2=110, MLD=001, MST=010, EXE=011, WB=100.
- tcb_vld  input  1  TCB request valid.
- tcb_rdy  input  1  TCB ready; trn = vld & rdy.
- tcb_wen  input  1  write enable.
- tcb_adr  input  32  address.
- tcb_siz  input  2  log2 transfer size.
- tcb_uns  input  1  unsigned flag; {uns,siz} equals func3.
- tcb_wdt  input  32  write data.
- tcb_rdt  input  32  read data, valid 1 cycle after trn (DLY=1).
- tcb_err  input  1  response error, valid 1 cycle after trn.
- trc_vld  output  1  record available.
- trc_rdy  input  1  sink accepts record.
- trc_pc  output  32  instruction address.
- trc_ins  output  32  instruction word.
- trc_rdv  output  1  GPR write occurred.
- trc_rdi  output  5  destination GPR index.
- trc_rdd  output  32  GPR write data.
- trc_ldv  output  1  load occurred.
- trc_stv  output  1  store occurred.
- trc_mad  output  32  memory address.
- trc_mdt  output  32  load data (rdt) or store data (wdt).
- trc_err  output  1  OR of response errors within the record.
- ovf_cnt  output  CNT_W  dropped records, saturating.

Behaviour:
- Stage D: on trn, register pha, adr, wen, siz, uns, wdt and d_trn=1; otherwise d_trn=0.
- Stage C: when d_trn=1, data = d_wen ? d_wdt : tcb_rdt; error = tcb_err. Update the assembly record by d_pha:
  - IF: close the open record (see emit rule), then open a new one: pc=adr, ins=rdt; clear rdv, ldv, stv, err.
  - WB: only if {uns,siz}==3'b010 (x0 writes use a different size and are ignored): rdv=1, rdi=adr[6:2], rdd=data.
  - MLD: ldv=1, mad=adr, mdt=rdt.
  - MST: stv=1, mad=adr, mdt=wdt.
  - RS1/RS2/EXE: no capture; their err is still ORed into the record.
- Emit rule:
  - A record is pushed only at the IF that follows it; the trace lags retirement by one instruction fetch.
  - Flag open is cleared by reset and set by the first IF. The first IF after reset (reset JAL) emits nothing.
- FIFO:
  - DEPTH entries; push = emit; pop = trc_vld & trc_rdy.
  - Output fields come directly from the head entry. trc_vld=1 iff not empty.
  - Push while full and no pop: drop the record, ovf_cnt += 1, saturate at 2^CNT_W-1.
  - Push while full with pop in the same cycle: accepted, no drop.
  - Pop while empty: ignored.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- Latency: IF trn at cycle N → record visible on trc_* at cycle N+2 if the FIFO was empty.
- Reset (also mid-operation):
  - Outputs: trc_vld=0, all trc_* data fields 0, ovf_cnt=0.
  - FIFO emptied, open=0, d_trn=0.
  - The partial record is discarded. Stage-D data registers need no reset.
- Back-to-back transfers every cycle are supported; no tcb input is ever back-pressured (the block is passive).

Test Plan:
- Reset, then IF@0x0 (JAL), then IF@0x80 ins 0x00500093, WB x1 0x5 (siz=10), then IF@0x84 → exactly one record: pc=0x80, ins=0x00500093, rdv=1, rdi=1, rdd=0x5, ldv=stv=0.
- Record containing MLD adr 0x1000 with rdt 0xDEADBEEF at N+1 → ldv=1, mad=0x1000, mdt=0xDEADBEEF.
- Record containing MST adr 0x2004 with wdt 0x12345678 → stv=1, mad=0x2004, mdt=0x12345678.
- WB with {uns,siz}=3'b000 (x0 write) → rdv=0. tcb_err=1 during RS1 → trc_err=1.
- trc_rdy=0 and DEPTH+3 records emitted → DEPTH records held, ovf_cnt=3. Then trc_rdy=1 → records drain in order and trc_vld drops after the last.
- FIFO full with push and pop in the same cycle → occupancy stays DEPTH, ovf_cnt unchanged. Assert rst mid-record → trc_vld=0 next cycle, and the next two IFs yield no record until the third.
